// File: rtl/cu_engine_m_axi_cmd_scheduler_pkg.sv
// Shared types and constants for the CU engine M_AXI read-command scheduler.
package cu_engine_m_axi_cmd_scheduler_pkg;

  localparam int CU_ENGINE_COUNT_TOTAL    = 8;
  localparam int CU_M_AXI_ADDR_W          = 64;
  localparam int CU_M_AXI_LEN_W           = 8;
  localparam int CU_M_AXI_ID_W            = 3;
  localparam int CU_M_AXI_MAX_OUTSTANDING = 16;

  typedef enum logic [4:0] {
    ST_RESET     = 5'b00001,
    ST_READY     = 5'b00010,
    ST_CMD_TRANS = 5'b00100,
    ST_PEND      = 5'b01000,
    ST_DONE      = 5'b10000
  } cu_engine_m_axi_state;

  typedef struct packed {
    logic [CU_M_AXI_ADDR_W-1:0] addr;
    logic [CU_M_AXI_LEN_W-1:0]  len;
    logic [CU_M_AXI_ID_W-1:0]   id;
  } cu_m_axi_cmd_t;

endpackage

// File: rtl/cu_round_robin_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after the
// pointer, wrapping, returned as a one-hot grant plus its index.
module cu_round_robin_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic             found;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/cu_engine_m_axi_cmd_scheduler.sv
// Shares one M_AXI AR channel between the engine lanes, round-robin, and
// bounds in-flight bursts by counting rlast completions.
//
//  state     | meaning
//  RESET     | held in reset; rready low
//  READY     | pick a winner, pop it, latch its command
//  CMD_TRANS | arvalid high with latched command until arready
//  PEND      | at outstanding limit or draining after start_in fell
//  DONE      | drained with start_in low; wait for start_in
module cu_engine_m_axi_cmd_scheduler
  import cu_engine_m_axi_cmd_scheduler_pkg::*;
#(
  parameter int NUM_REQ         = CU_ENGINE_COUNT_TOTAL,
  parameter int ADDR_W          = CU_M_AXI_ADDR_W,
  parameter int LEN_W           = CU_M_AXI_LEN_W,
  parameter int ID_W            = CU_M_AXI_ID_W,
  parameter int MAX_OUTSTANDING = CU_M_AXI_MAX_OUTSTANDING
) (
  input  logic                                     ap_clk,
  input  logic                                     areset,
  input  logic                                     start_in,
  input  logic [NUM_REQ-1:0]                       req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0]                req_addr_in,
  input  logic [NUM_REQ*LEN_W-1:0]                 req_len_in,
  output logic [NUM_REQ-1:0]                       req_ready_out,
  output logic                                     m_axi_arvalid,
  output logic [ADDR_W-1:0]                        m_axi_araddr,
  output logic [LEN_W-1:0]                         m_axi_arlen,
  output logic [ID_W-1:0]                          m_axi_arid,
  input  logic                                     m_axi_arready,
  input  logic                                     m_axi_rvalid,
  input  logic                                     m_axi_rlast,
  output logic                                     m_axi_rready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_out,
  output logic [4:0]                               state_out,
  output logic                                     done_out,
  output logic                                     error_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  cu_engine_m_axi_state state_q, state_d;
  cu_m_axi_cmd_t        cmd_q, cmd_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_req;
  logic                 ar_hs;
  logic                 r_done;
  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [LEN_W-1:0]     len_arr  [NUM_REQ];

  cu_round_robin_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req_valid_in),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr_in[i*ADDR_W +: ADDR_W];
      len_arr[i]  = req_len_in[i*LEN_W +: LEN_W];
    end
  end

  assign ar_hs  = (state_q == ST_CMD_TRANS) && m_axi_arready;
  assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  // A simultaneous issue and completion cancel; a completion with nothing
  // in flight is a protocol error and must not wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (ar_hs && !r_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (r_done && !ar_hs) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    ptr_d         = ptr_q;
    req_ready_out = '0;
    case (state_q)
      ST_RESET: state_d = ST_READY;
      ST_READY: begin
        if (start_in && any_req && (cnt_q < MAX_CNT)) begin
          cmd_d.addr    = addr_arr[win_idx];
          cmd_d.len     = len_arr[win_idx];
          cmd_d.id      = ID_W'(win_idx);
          req_ready_out = gnt;
          ptr_d         = win_idx;
          state_d       = ST_CMD_TRANS;
        end else if (!start_in) begin
          state_d = ST_PEND;
        end
      end
      ST_CMD_TRANS: begin
        if (ar_hs) state_d = (cnt_d < MAX_CNT) ? ST_READY : ST_PEND;
      end
      ST_PEND: begin
        if ((cnt_q < MAX_CNT) && start_in)  state_d = ST_READY;
        else if (!start_in && cnt_q == '0)  state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start_in) state_d = ST_READY;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_RESET;
      cmd_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign m_axi_arvalid   = (state_q == ST_CMD_TRANS);
  assign m_axi_araddr    = cmd_q.addr;
  assign m_axi_arlen     = cmd_q.len;
  assign m_axi_arid      = cmd_q.id;
  assign m_axi_rready    = (state_q != ST_RESET);
  assign outstanding_out = cnt_q;
  assign state_out       = state_q;
  assign done_out        = (state_q == ST_DONE);
  assign error_out       = err_q;

endmodule

// File: tb/tb_cu_engine_m_axi_cmd_scheduler.sv
// Directed bench for the M_AXI command scheduler: a cycle-level behavioural
// model checked on every falling edge, plus literal expectations per scenario.
module tb_cu_engine_m_axi_cmd_scheduler;

  localparam int NR   = 8;
  localparam int AW   = 64;
  localparam int LW   = 8;
  localparam int IW   = 3;
  localparam int MAXO = 16;
  localparam int CW   = 5;

  localparam int P_RESET = 0;
  localparam int P_READY = 1;
  localparam int P_CMD   = 2;
  localparam int P_PEND  = 3;
  localparam int P_DONE  = 4;

  logic             ap_clk = 1'b0;
  logic             areset = 1'b0;
  logic             start_in = 1'b0;
  logic [NR-1:0]    req_valid_in = '0;
  logic [NR*AW-1:0] req_addr_in;
  logic [NR*LW-1:0] req_len_in;
  logic [NR-1:0]    req_ready_out;
  logic             m_axi_arvalid;
  logic [AW-1:0]    m_axi_araddr;
  logic [LW-1:0]    m_axi_arlen;
  logic [IW-1:0]    m_axi_arid;
  logic             m_axi_arready = 1'b0;
  logic             m_axi_rvalid = 1'b0;
  logic             m_axi_rlast = 1'b0;
  logic             m_axi_rready;
  logic [CW-1:0]    outstanding_out;
  logic [4:0]       state_out;
  logic             done_out;
  logic             error_out;

  always #5 ap_clk = ~ap_clk;

  cu_engine_m_axi_cmd_scheduler dut (
    .ap_clk          (ap_clk),
    .areset          (areset),
    .start_in        (start_in),
    .req_valid_in    (req_valid_in),
    .req_addr_in     (req_addr_in),
    .req_len_in      (req_len_in),
    .req_ready_out   (req_ready_out),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_arlen     (m_axi_arlen),
    .m_axi_arid      (m_axi_arid),
    .m_axi_arready   (m_axi_arready),
    .m_axi_rvalid    (m_axi_rvalid),
    .m_axi_rlast     (m_axi_rlast),
    .m_axi_rready    (m_axi_rready),
    .outstanding_out (outstanding_out),
    .state_out       (state_out),
    .done_out        (done_out),
    .error_out       (error_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Per-requester command payloads
  logic [AW-1:0] a_tab [NR];
  logic [LW-1:0] l_tab [NR];

  // Behavioural model: phase, in-flight count, sticky error, RR pointer and the
  // command currently being offered on AR.
  int            m_ph   = P_RESET;
  int            m_cnt  = 0;
  int            m_ptr  = NR - 1;
  int            m_id   = 0;
  bit            m_err  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_len  = '0;

  function automatic int pick();
    logic [2:0] ci;
    for (int k = 1; k <= NR; k++) begin
      ci = 3'((m_ptr + k) % NR);
      if (req_valid_in[ci]) return int'(ci);
    end
    return -1;
  endfunction

  function automatic int exp_grant();
    if (m_ph == P_READY && start_in && m_cnt < MAXO) return pick();
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit hs;
    bit comp;
    int nc;
    if (areset) begin
      m_ph = P_RESET; m_cnt = 0; m_ptr = NR - 1; m_id = 0;
      m_err = 1'b0; m_addr = '0; m_len = '0;
    end else begin
      w    = exp_grant();
      hs   = (m_ph == P_CMD) && m_axi_arready;
      comp = m_axi_rvalid && m_axi_rlast && (m_ph != P_RESET);
      nc   = m_cnt;
      if (hs && !comp) nc = m_cnt + 1;
      else if (comp && !hs) begin
        if (m_cnt == 0) m_err = 1'b1;
        else nc = m_cnt - 1;
      end
      case (m_ph)
        P_RESET: m_ph = P_READY;
        P_READY: begin
          if (w >= 0) begin
            m_addr = a_tab[w]; m_len = l_tab[w]; m_id = w; m_ptr = w; m_ph = P_CMD;
          end else if (!start_in) m_ph = P_PEND;
        end
        P_CMD:   if (hs) m_ph = (nc < MAXO) ? P_READY : P_PEND;
        P_PEND: begin
          if (m_cnt < MAXO && start_in) m_ph = P_READY;
          else if (!start_in && m_cnt == 0) m_ph = P_DONE;
        end
        P_DONE:  if (start_in) m_ph = P_READY;
        default: m_ph = P_RESET;
      endcase
      m_cnt = nc;
    end
  endtask

  int gq[$];

  task automatic compare_now();
    int w;
    w = exp_grant();
    chk("state",       64'(state_out),       64'(1) << m_ph);
    chk("arvalid",     64'(m_axi_arvalid),   64'(m_ph == P_CMD));
    chk("rready",      64'(m_axi_rready),    64'(m_ph != P_RESET));
    chk("done",        64'(done_out),        64'(m_ph == P_DONE));
    chk("error",       64'(error_out),       64'(m_err));
    chk("outstanding", 64'(outstanding_out), 64'(m_cnt));
    chk("ready_out",   64'(req_ready_out),   (w >= 0) ? (64'(1) << w) : 64'(0));
    if (m_ph == P_CMD) begin
      chk("araddr", 64'(m_axi_araddr), 64'(m_addr));
      chk("arlen",  64'(m_axi_arlen),  64'(m_len));
      chk("arid",   64'(m_axi_arid),   64'(m_id));
    end
    for (int i = 0; i < NR; i++) if (req_ready_out[i]) gq.push_back(i);
  endtask

  initial forever begin
    @(posedge ap_clk or posedge areset);
    model_step();
  end

  initial forever begin
    @(negedge ap_clk);
    compare_now();
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge ap_clk); #1; end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step(2);
    areset = 1'b0;
    step(1);
  endtask

  task automatic pulse_rlast();
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    step(1);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < NR; i++) begin
      a_tab[i] = 64'h1000 + 64'(i) * 64'h100;
      l_tab[i] = 8'(i + 3);
      req_addr_in[i*AW +: AW] = a_tab[i];
      req_len_in[i*LW +: LW]  = l_tab[i];
    end
    #1 areset = 1'b1;

    // Reset values
    step(2);
    @(negedge ap_clk);
    chk("rst_state",   64'(state_out),       64'h01);
    chk("rst_arvalid", 64'(m_axi_arvalid),   64'h0);
    chk("rst_araddr",  64'(m_axi_araddr),    64'h0);
    chk("rst_rready",  64'(m_axi_rready),    64'h0);
    chk("rst_ready",   64'(req_ready_out),   64'h0);
    chk("rst_out",     64'(outstanding_out), 64'h0);

    // Release, single request from lane 0
    step(1);
    areset = 1'b0; start_in = 1'b1; req_valid_in = 8'h01;
    step(1);
    @(negedge ap_clk);
    chk("release_ready_state", 64'(state_out),     64'h02);
    chk("single_pop",          64'(req_ready_out), 64'h01);
    step(1);
    req_valid_in = 8'h00;
    @(negedge ap_clk);
    chk("single_arvalid", 64'(m_axi_arvalid), 64'h1);
    chk("single_araddr",  64'(m_axi_araddr),  64'h1000);
    chk("single_arlen",   64'(m_axi_arlen),   64'h3);
    chk("single_arid",    64'(m_axi_arid),    64'h0);

    // arready withheld: payload stable, no new grant
    for (int i = 0; i < 5; i++) begin
      step(1);
      req_valid_in = 8'h02;
      @(negedge ap_clk);
      chk("hold_arvalid", 64'(m_axi_arvalid), 64'h1);
      chk("hold_araddr",  64'(m_axi_araddr),  64'h1000);
      chk("hold_arid",    64'(m_axi_arid),    64'h0);
      chk("hold_nogrant", 64'(req_ready_out), 64'h0);
    end
    step(1);
    m_axi_arready = 1'b1;
    step(1);
    @(negedge ap_clk);
    chk("hs_count",   64'(outstanding_out), 64'h1);
    chk("next_grant", 64'(req_ready_out),   64'h02);
    step(1);
    req_valid_in = 8'h00;
    step(2);

    // All lanes valid: round-robin order from a fresh pointer
    start_in = 1'b0; req_valid_in = 8'h00;
    do_reset();
    start_in = 1'b1; req_valid_in = 8'hFF;
    gq.delete();
    step(18);
    req_valid_in = 8'h00;
    @(negedge ap_clk);
    chk("rr_count", 64'(gq.size()), 64'd9);
    for (int i = 0; i < 9 && i < gq.size(); i++) chk("rr_order", 64'(gq[i]), 64'(i % 8));
    chk("rr_outstanding", 64'(outstanding_out), 64'd9);

    // Fill to the limit, then one completion frees a slot
    step(1);
    req_valid_in = 8'hFF;
    for (int i = 0; i < 40 && state_out != 5'b01000; i++) @(negedge ap_clk);
    chk("max_state",   64'(state_out),       64'h08);
    chk("max_count",   64'(outstanding_out), 64'd16);
    chk("max_nogrant", 64'(req_ready_out),   64'h0);
    pulse_rlast();
    @(negedge ap_clk);
    chk("max_dec", 64'(outstanding_out), 64'd15);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge ap_clk);
      if (req_ready_out != '0) seen = 1'b1;
    end
    chk("regrant_after_rlast", 64'(seen), 64'h1);

    // AR handshake and completion in the same cycle
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge ap_clk);
      if (m_axi_arvalid) seen = 1'b1;
    end
    chk("same_cycle_arvalid", 64'(seen), 64'h1);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    step(1);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(negedge ap_clk);
    chk("same_cycle_count", 64'(outstanding_out), 64'd15);
    chk("same_cycle_noerr", 64'(error_out),       64'h0);

    // Spurious completion with nothing in flight
    step(1);
    start_in = 1'b0; req_valid_in = 8'h00;
    do_reset();
    start_in = 1'b1;
    @(negedge ap_clk);
    chk("pre_spur_error", 64'(error_out),       64'h0);
    chk("pre_spur_count", 64'(outstanding_out), 64'h0);
    pulse_rlast();
    @(negedge ap_clk);
    chk("spur_error", 64'(error_out),       64'h1);
    chk("spur_count", 64'(outstanding_out), 64'h0);
    step(2);
    @(negedge ap_clk);
    chk("spur_sticky", 64'(error_out), 64'h1);

    // Drain: start_in falls with three bursts in flight
    step(1);
    start_in = 1'b0;
    do_reset();
    start_in = 1'b1; req_valid_in = 8'h01; m_axi_arready = 1'b1;
    @(negedge ap_clk);
    chk("reset_clears_error", 64'(error_out), 64'h0);
    for (int i = 0; i < 20 && outstanding_out != 5'd3; i++) @(negedge ap_clk);
    chk("drain_inflight", 64'(outstanding_out), 64'd3);
    #2;
    req_valid_in = 8'h00; start_in = 1'b0;
    step(2);
    @(negedge ap_clk);
    chk("drain_pend", 64'(state_out), 64'h08);
    pulse_rlast(); step(1);
    pulse_rlast(); step(1);
    @(negedge ap_clk);
    chk("drain_not_done", 64'(state_out), 64'h08);
    pulse_rlast(); step(1);
    @(negedge ap_clk);
    chk("drain_done_state", 64'(state_out), 64'h10);
    chk("drain_done_flag",  64'(done_out),  64'h1);
    start_in = 1'b1;
    step(1);
    @(negedge ap_clk);
    chk("restart_done_clear", 64'(done_out),  64'h0);
    chk("restart_ready",      64'(state_out), 64'h02);

    // Asynchronous reset while an AR is being offered
    step(1);
    req_valid_in = 8'h01; m_axi_arready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge ap_clk);
      if (m_axi_arvalid) seen = 1'b1;
    end
    chk("midcmd_arvalid_seen", 64'(seen), 64'h1);
    #2 areset = 1'b1;
    #1;
    chk("midcmd_arvalid_drop", 64'(m_axi_arvalid), 64'h0);
    chk("midcmd_state",        64'(state_out),     64'h01);
    step(1);
    req_valid_in = 8'h00; areset = 1'b0;
    step(4);
    @(negedge ap_clk);
    chk("no_reissue", 64'(m_axi_arvalid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
